// File: rtl/store_buffer.sv
// store_buffer: in-order store FIFO ahead of data memory, youngest-match load forwarding.
// Optional store coalescing into the youngest entry: define STORE_COALESCE_EN.
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 8,
  parameter int DW    = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     st_valid,
  input  logic [AW-1:0]            st_addr,
  input  logic [DW-1:0]            st_data,
  output logic                     st_ready,
  input  logic [AW-1:0]            ld_addr,
  output logic                     ld_hit,
  output logic [DW-1:0]            ld_data,
  input  logic                     mem_busy,
  output logic                     mem_dwe,
  output logic [AW-1:0]            mem_addr,
  output logic [DW-1:0]            mem_wdata,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0] r_addr [DEPTH];
  logic [DW-1:0] r_data [DEPTH];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;

  logic          w_empty;
  logic          w_full;
  logic          w_push;
  logic          w_pop;
  logic          w_coal;
  logic [PW-1:0] w_young;
  logic [PW-1:0] w_idx;
  logic          w_hit;
  logic [DW-1:0] w_ld;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CW'(DEPTH));
  assign w_young = r_tail - PW'(1);
  assign w_pop   = !w_empty && !mem_busy;

`ifdef STORE_COALESCE_EN
  // The youngest entry may absorb a same-address store unless it leaves now.
  assign w_coal = st_valid && !w_empty &&
                  (st_addr == r_addr[w_young]) &&
                  (!w_pop || (r_count > CW'(1)));
`else
  assign w_coal = 1'b0;
`endif

  assign st_ready = w_coal || !w_full;
  assign w_push   = st_valid && st_ready && !w_coal;

  // Head/tail pointers and occupancy; reset discards pending stores.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + PW'(1);
      if (w_pop)  r_head <= r_head + PW'(1);
      r_count <= r_count + {{PW{1'b0}}, w_push}
                         - {{PW{1'b0}}, w_pop};
    end
  end

  // Entry payload; contents are only meaningful under count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr[r_tail] <= st_addr;
      r_data[r_tail] <= st_data;
    end else if (w_coal) begin
      r_data[w_young] <= st_data;
    end
  end

  // Scan oldest to youngest so the last match is the youngest store.
  always_comb begin
    w_hit = 1'b0;
    w_ld  = '0;
    w_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_idx = r_head + PW'(i);
      if ((CW'(i) < r_count) && (r_addr[w_idx] == ld_addr)) begin
        w_hit = 1'b1;
        w_ld  = r_data[w_idx];
      end
    end
  end

  assign ld_hit    = w_hit;
  assign ld_data   = w_ld;
  assign mem_dwe   = w_pop;
  assign mem_addr  = w_empty ? '0 : r_addr[r_head];
  assign mem_wdata = w_empty ? '0 : r_data[r_head];
  assign empty     = w_empty;
  assign count     = r_count;

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- In-order FIFO of pending stores that sits directly upstream of the data memory in the pipeline CPU's MEM stage.
- Stores from the EX/MEM register are accepted at one per cycle.
- Entries drain one per cycle into the data memory write port whenever the load path is not using that port.
- Loads are forwarded from the youngest matching buffered store, so the pipeline observes program-order memory semantics.

Parameters:
DEPTH  4  number of buffer entries; power of two, >= 2
AW  8  address width, matching the data memory address
DW  16  data width, matching the data memory word

Ports:
clk  input  1  clock; all state updates on posedge
rst  input  1  asynchronous active-low reset
st_valid  input  1  store request from EX/MEM
st_addr  input  AW  store address
st_data  input  DW  store data
st_ready  output  1  buffer can accept a store this cycle
ld_addr  input  AW  address of the load currently in MEM
ld_hit  output  1  a buffered store matches ld_addr
ld_data  output  DW  data of the youngest matching entry (0 when no hit)
mem_busy  input  1  data memory port reserved by the load path this cycle
mem_dwe  output  1  write enable to data memory
mem_addr  output  AW  write address to data memory (head entry)
mem_wdata  output  DW  write data to data memory (head entry)
empty  output  1  no pending stores
count  output  $clog2(DEPTH)+1  number of valid entries

Behaviour:
- Storage and state:
  - Circular array of DEPTH entries {addr, data}.
  - State is head pointer, tail pointer and count register; no other state.
- Reset:
  - rst low clears head, tail and count immediately (asynchronous). Pending stores are discarded.
  - Entry contents need not be cleared.
  - Resulting outputs: empty=1, count=0, st_ready=1, mem_dwe=0, ld_hit=0, ld_data=0.
  - Reset asserted mid-drain: no further writes are issued; the write already committed at the prior edge stands.
- Push:
  - st_ready = (count != DEPTH). It depends on registered count only, never on a same-cycle drain.
  - When st_valid & st_ready, write {st_addr, st_data} at tail, tail+1 mod DEPTH, at the posedge.
  - st_valid while st_ready=0 is ignored. The pipeline must stall; the buffer holds no request.
- Drain:
  - mem_dwe = !empty & !mem_busy, combinational.
  - mem_addr and mem_wdata always show the head entry, or 0 when empty.
  - When mem_dwe=1, the data memory captures the write at the posedge, and head advances mod DEPTH at the same edge. One write per cycle; strict FIFO order.
- Count:
  - push only: +1; pop only: -1; push and pop together: unchanged.
  - Full with a pop in the same cycle: no push, count becomes DEPTH-1, st_ready rises next cycle.
  - Empty with a push in the same cycle: no pop, since mem_dwe=0 while empty. The entry drains at the earliest on the next cycle.
- Forwarding:
  - Combinational over valid entries. ld_hit=1 if any valid entry addr == ld_addr.
  - ld_data is taken from the youngest matching entry, i.e. nearest to tail.
  - The head entry being drained this cycle still counts as valid.
  - A store presented on st_valid in the same cycle is not forwarded. It is visible to loads from the next cycle.
- Pointer wrap: head and tail wrap modulo DEPTH; count distinguishes full from empty.

Optional Feature:
- Macro: STORE_COALESCE_EN.
- Defined, coalescing applies when all of the following hold:
  - st_valid is high,
  - count > 0,
  - st_addr equals the youngest entry's addr,
  - that entry is not the head being popped this cycle (mem_dwe=0, or count > 1).
- When coalescing applies: the youngest entry's data is overwritten with st_data; tail and count are unchanged.
- While coalescing is possible, st_ready is 1 even when full.
- Undefined: every accepted store allocates a new entry; st_ready = (count != DEPTH).

Test Plan:
1. Reset then push addr 8'h03 data 16'h1234 with mem_busy=0. Response: count=1 for one cycle; next cycle mem_dwe=1, mem_addr=03, mem_wdata=1234; following cycle empty=1.
2. Hold mem_busy=1 and push 4 stores to addresses 0..3 with data A0..A3. Response: count=4, st_ready=0, and a 5th store is ignored. Release mem_busy: writes appear in order 0..3 on consecutive cycles.
3. Buffer holds addr 05 with data 1111, then addr 05 with data 2222, and mem_busy=1. Drive ld_addr=05: ld_hit=1, ld_data=2222. Drive ld_addr=06: ld_hit=0, ld_data=0.
4. Buffer is full with mem_busy=0, and st_valid is held high. Response: pop occurs without a push; count=3 next cycle with st_ready=1; then push and pop together hold count at 3.
5. Assert rst low mid-drain with 3 entries pending. Response: mem_dwe=0 immediately, count=0, empty=1; no further writes after release.
6. STORE_COALESCE_EN defined, mem_busy=1, store addr 07 data 0001 then addr 07 data 0002. Response: count=1, ld_data=0002, and exactly one write of 0002 after release. Without the macro: count=2 and two writes.
